// File: rtl/riscv_com_queue.sv
// In-order commit buffer between writeback and architectural state.
// Retires up to COMMIT_W entries per cycle and raises a precise trap at the first excepting entry.
module riscv_com_queue #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned COMMIT_W = 2,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COMMIT_W-1:0]      wb_valid,
  output logic                     wb_ready,
  input  logic [COMMIT_W*XLEN-1:0] wb_pc,
  input  logic [COMMIT_W*32-1:0]   wb_inst,
  input  logic [COMMIT_W*XLEN-1:0] wb_data,
  input  logic [COMMIT_W*5-1:0]    wb_rd_addr,
  input  logic [COMMIT_W-1:0]      wb_wr_en,
  input  logic [COMMIT_W-1:0]      wb_exc,
  input  logic [COMMIT_W*4-1:0]    wb_cause,
  input  logic                     com_stall,
  output logic [COMMIT_W-1:0]      com_valid,
  output logic [COMMIT_W*XLEN-1:0] com_pc,
  output logic [COMMIT_W*32-1:0]   com_inst,
  output logic [COMMIT_W*XLEN-1:0] com_data,
  output logic [COMMIT_W*5-1:0]    com_rd_addr,
  output logic [COMMIT_W-1:0]      com_wr_en,
  output logic                     trap_valid,
  output logic [XLEN-1:0]          trap_pc,
  output logic [3:0]               trap_cause,
  output logic [XLEN-1:0]          retire_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] data;
    logic [4:0]      rd_addr;
    logic            wr_en;
    logic            exc;
    logic [3:0]      cause;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  entry_t           head_ent [COMMIT_W];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [CNT_W-1:0] n_avail;
  logic [CNT_W-1:0] n_ret;
  logic [CNT_W-1:0] n_acc;
  logic [COMMIT_W-1:0] ret_mask;
  logic             flush_now;
  logic             blocked;
  logic             accept;
  logic [XLEN-1:0]  exc_pc;
  logic [3:0]       exc_cause;

  logic [COMMIT_W-1:0]      com_valid_q, com_valid_d;
  logic [COMMIT_W*XLEN-1:0] com_pc_q, com_pc_d;
  logic [COMMIT_W*32-1:0]   com_inst_q, com_inst_d;
  logic [COMMIT_W*XLEN-1:0] com_data_q, com_data_d;
  logic [COMMIT_W*5-1:0]    com_rd_addr_q, com_rd_addr_d;
  logic [COMMIT_W-1:0]      com_wr_en_q, com_wr_en_d;
  logic                     trap_valid_q, trap_valid_d;
  logic [XLEN-1:0]          trap_pc_q, trap_pc_d;
  logic [3:0]               trap_cause_q, trap_cause_d;
  logic [XLEN-1:0]          retire_cnt_q, retire_cnt_d;

  always_comb begin
    for (int unsigned k = 0; k < COMMIT_W; k++) begin
      head_ent[k] = mem_q[head_q + PTR_W'(k)];
    end
  end

  // Retire in order from head; stop at the first excepting entry, which traps instead of retiring.
  always_comb begin
    n_avail   = (count_q < CNT_W'(COMMIT_W)) ? count_q : CNT_W'(COMMIT_W);
    ret_mask  = '0;
    n_ret     = '0;
    flush_now = 1'b0;
    exc_pc    = '0;
    exc_cause = '0;
    blocked   = com_stall;
    for (int unsigned k = 0; k < COMMIT_W; k++) begin
      if (!blocked && (CNT_W'(k) < n_avail)) begin
        if (head_ent[k].exc) begin
          flush_now = 1'b1;
          exc_pc    = head_ent[k].pc;
          exc_cause = head_ent[k].cause;
          blocked   = 1'b1;
        end else begin
          ret_mask[k] = 1'b1;
          n_ret       = n_ret + CNT_W'(1);
        end
      end
    end
  end

  assign wb_ready = ((CNT_W'(DEPTH) - count_q) >= CNT_W'(COMMIT_W)) && !flush_now && !rst;
  assign accept   = wb_ready && wb_valid[0];

  always_comb begin
    n_acc = '0;
    mem_d = mem_q;
    if (accept) begin
      for (int unsigned k = 0; k < COMMIT_W; k++) begin
        if (wb_valid[k]) begin
          n_acc = n_acc + CNT_W'(1);
          mem_d[tail_q + PTR_W'(k)].pc      = wb_pc[k*XLEN +: XLEN];
          mem_d[tail_q + PTR_W'(k)].inst    = wb_inst[k*32 +: 32];
          mem_d[tail_q + PTR_W'(k)].data    = wb_data[k*XLEN +: XLEN];
          mem_d[tail_q + PTR_W'(k)].rd_addr = wb_rd_addr[k*5 +: 5];
          mem_d[tail_q + PTR_W'(k)].wr_en   = wb_wr_en[k];
          mem_d[tail_q + PTR_W'(k)].exc     = wb_exc[k];
          mem_d[tail_q + PTR_W'(k)].cause   = wb_cause[k*4 +: 4];
        end
      end
    end
  end

  // A flush empties the buffer by snapping head onto tail; accept is already refused that cycle.
  always_comb begin
    head_d  = head_q + PTR_W'(n_ret);
    tail_d  = tail_q + PTR_W'(n_acc);
    count_d = count_q + n_acc - n_ret;
    if (flush_now) begin
      head_d  = tail_q;
      tail_d  = tail_q;
      count_d = '0;
    end
  end

  always_comb begin
    com_valid_d   = ret_mask;
    com_pc_d      = com_pc_q;
    com_inst_d    = com_inst_q;
    com_data_d    = com_data_q;
    com_rd_addr_d = com_rd_addr_q;
    com_wr_en_d   = '0;
    for (int unsigned k = 0; k < COMMIT_W; k++) begin
      if (ret_mask[k]) begin
        com_pc_d[k*XLEN +: XLEN]   = head_ent[k].pc;
        com_inst_d[k*32 +: 32]     = head_ent[k].inst;
        com_data_d[k*XLEN +: XLEN] = head_ent[k].data;
        com_rd_addr_d[k*5 +: 5]    = head_ent[k].rd_addr;
        com_wr_en_d[k]             = head_ent[k].wr_en;
      end
    end
    trap_valid_d = flush_now;
    trap_pc_d    = flush_now ? exc_pc : trap_pc_q;
    trap_cause_d = flush_now ? exc_cause : trap_cause_q;
    retire_cnt_d = retire_cnt_q + XLEN'(n_ret);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      com_valid_q   <= '0;
      com_pc_q      <= '0;
      com_inst_q    <= '0;
      com_data_q    <= '0;
      com_rd_addr_q <= '0;
      com_wr_en_q   <= '0;
      trap_valid_q  <= 1'b0;
      trap_pc_q     <= '0;
      trap_cause_q  <= '0;
      retire_cnt_q  <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      com_valid_q   <= com_valid_d;
      com_pc_q      <= com_pc_d;
      com_inst_q    <= com_inst_d;
      com_data_q    <= com_data_d;
      com_rd_addr_q <= com_rd_addr_d;
      com_wr_en_q   <= com_wr_en_d;
      trap_valid_q  <= trap_valid_d;
      trap_pc_q     <= trap_pc_d;
      trap_cause_q  <= trap_cause_d;
      retire_cnt_q  <= retire_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign com_valid   = com_valid_q;
  assign com_pc      = com_pc_q;
  assign com_inst    = com_inst_q;
  assign com_data    = com_data_q;
  assign com_rd_addr = com_rd_addr_q;
  assign com_wr_en   = com_wr_en_q;
  assign trap_valid  = trap_valid_q;
  assign trap_pc     = trap_pc_q;
  assign trap_cause  = trap_cause_q;
  assign retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_riscv_com_queue.sv
// Directed bench for riscv_com_queue (XLEN=64, COMMIT_W=2, DEPTH=8): vector table plus reset and wrap sequences.
module tb_riscv_com_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   wb_valid;
  logic         wb_ready;
  logic [127:0] wb_pc;
  logic [63:0]  wb_inst;
  logic [127:0] wb_data;
  logic [9:0]   wb_rd_addr;
  logic [1:0]   wb_wr_en;
  logic [1:0]   wb_exc;
  logic [7:0]   wb_cause;
  logic         com_stall;
  logic [1:0]   com_valid;
  logic [127:0] com_pc;
  logic [63:0]  com_inst;
  logic [127:0] com_data;
  logic [9:0]   com_rd_addr;
  logic [1:0]   com_wr_en;
  logic         trap_valid;
  logic [63:0]  trap_pc;
  logic [3:0]   trap_cause;
  logic [63:0]  retire_cnt;

  int total = 0;
  int bad   = 0;

  riscv_com_queue #(.XLEN(64), .COMMIT_W(2), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_data(wb_data), .wb_rd_addr(wb_rd_addr),
    .wb_wr_en(wb_wr_en), .wb_exc(wb_exc), .wb_cause(wb_cause), .com_stall(com_stall),
    .com_valid(com_valid), .com_pc(com_pc), .com_inst(com_inst), .com_data(com_data),
    .com_rd_addr(com_rd_addr), .com_wr_en(com_wr_en), .trap_valid(trap_valid),
    .trap_pc(trap_pc), .trap_cause(trap_cause), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert (rst || wb_valid != 2'b10) else $error("illegal non-contiguous wb_valid");
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  typedef struct {
    logic        rst;
    logic        stall;
    logic [1:0]  valid;
    logic [63:0] pc0;
    logic [63:0] pc1;
    logic [1:0]  exc;
    logic [3:0]  cause;
    logic        e_ready;
    logic [1:0]  e_cv;
    logic [63:0] e_pc0;
    logic [63:0] e_pc1;
    logic        e_trap;
    logic [63:0] e_tpc;
    logic [3:0]  e_tcause;
    logic [63:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic [1:0] v,
                       input logic [63:0] p0, input logic [63:0] p1,
                       input logic [1:0] e, input logic [3:0] c);
    rst        = r;
    com_stall  = st;
    wb_valid   = v;
    wb_pc      = {p1, p0};
    wb_inst    = {p1[31:0], p0[31:0]};
    wb_data    = {p1 + 64'h100, p0 + 64'h100};
    wb_rd_addr = {p1[6:2], p0[6:2]};
    wb_wr_en   = {~p1[4], ~p0[4]};
    wb_exc     = e;
    wb_cause   = {c, c};
  endtask

  function automatic vec_t mk(input logic r, input logic st, input logic [1:0] v,
                              input logic [63:0] p0, input logic [63:0] p1,
                              input logic [1:0] e, input logic [3:0] c,
                              input logic er, input logic [1:0] ecv,
                              input logic [63:0] ep0, input logic [63:0] ep1,
                              input logic et, input logic [63:0] etp, input logic [3:0] ec,
                              input logic [63:0] ecnt);
    vec_t x;
    x.rst = r; x.stall = st; x.valid = v; x.pc0 = p0; x.pc1 = p1; x.exc = e; x.cause = c;
    x.e_ready = er; x.e_cv = ecv; x.e_pc0 = ep0; x.e_pc1 = ep1;
    x.e_trap = et; x.e_tpc = etp; x.e_tcause = ec; x.e_cnt = ecnt;
    return x;
  endfunction

  initial begin
    vec_t v;
    logic [1:0]  exp_wr;
    logic [63:0] lane_pc;
    logic [63:0] pc0, pc1;
    int issued, retired, cyc;
    logic can, st;

    // reset, then two-lane issue/retire
    vecs.push_back(mk(1,0,2'b00,0,0,0,0,        0,2'b00,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,2'b11,'h1000,'h1004,0,0, 1,2'b00,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,2'b00,0,0,0,0,        1,2'b11,'h1000,'h1004,0,0,0,2));
    // fill to DEPTH under stall, then drain two per cycle
    vecs.push_back(mk(0,1,2'b11,'h3000,'h3004,0,0, 1,2'b00,0,0,0,0,0,2));
    vecs.push_back(mk(0,1,2'b11,'h3008,'h300c,0,0, 1,2'b00,0,0,0,0,0,2));
    vecs.push_back(mk(0,1,2'b11,'h3010,'h3014,0,0, 1,2'b00,0,0,0,0,0,2));
    vecs.push_back(mk(0,1,2'b11,'h3018,'h301c,0,0, 1,2'b00,0,0,0,0,0,2));
    vecs.push_back(mk(0,1,2'b11,'h3020,'h3024,0,0, 0,2'b00,0,0,0,0,0,2));
    vecs.push_back(mk(0,0,2'b00,0,0,0,0,        0,2'b11,'h3000,'h3004,0,0,0,4));
    vecs.push_back(mk(0,0,2'b00,0,0,0,0,        1,2'b11,'h3008,'h300c,0,0,0,6));
    vecs.push_back(mk(0,0,2'b00,0,0,0,0,        1,2'b11,'h3010,'h3014,0,0,0,8));
    vecs.push_back(mk(0,0,2'b00,0,0,0,0,        1,2'b11,'h3018,'h301c,0,0,0,10));
    vecs.push_back(mk(0,0,2'b00,0,0,0,0,        1,2'b00,0,0,0,0,0,10));
    // exception in lane 1 with a younger entry buffered behind it
    vecs.push_back(mk(0,1,2'b11,'h2000,'h2004,2'b10,2, 1,2'b00,0,0,0,0,0,10));
    vecs.push_back(mk(0,1,2'b01,'h2008,0,0,0,   1,2'b00,0,0,0,0,0,10));
    vecs.push_back(mk(0,0,2'b00,0,0,0,0,        0,2'b01,'h2000,0,1,'h2004,2,11));
    vecs.push_back(mk(0,0,2'b00,0,0,0,0,        1,2'b00,0,0,0,0,0,11));
    vecs.push_back(mk(0,0,2'b00,0,0,0,0,        1,2'b00,0,0,0,0,0,11));
    // exception at head held off by stall
    vecs.push_back(mk(0,1,2'b01,'h4000,0,2'b01,5, 1,2'b00,0,0,0,0,0,11));
    vecs.push_back(mk(0,1,2'b00,0,0,0,0,        1,2'b00,0,0,0,0,0,11));
    vecs.push_back(mk(0,0,2'b00,0,0,0,0,        0,2'b00,0,0,1,'h4000,5,11));
    vecs.push_back(mk(0,0,2'b00,0,0,0,0,        1,2'b00,0,0,0,0,0,11));
    // simultaneous accept and retire, then a single-lane retire
    vecs.push_back(mk(0,0,2'b11,'h5000,'h5004,0,0, 1,2'b00,0,0,0,0,0,11));
    vecs.push_back(mk(0,0,2'b11,'h5008,'h500c,0,0, 1,2'b11,'h5000,'h5004,0,0,0,13));
    vecs.push_back(mk(0,0,2'b00,0,0,0,0,        1,2'b11,'h5008,'h500c,0,0,0,15));
    vecs.push_back(mk(0,0,2'b00,0,0,0,0,        1,2'b00,0,0,0,0,0,15));
    vecs.push_back(mk(0,0,2'b01,'h6000,0,0,0,   1,2'b00,0,0,0,0,0,15));
    vecs.push_back(mk(0,0,2'b00,0,0,0,0,        1,2'b01,'h6000,0,0,0,0,16));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.rst, v.stall, v.valid, v.pc0, v.pc1, v.exc, v.cause);
      #1;
      chk($sformatf("r%0d wb_ready", i), {63'd0, wb_ready}, {63'd0, v.e_ready});
      @(posedge clk);
      #1;
      chk($sformatf("r%0d com_valid", i), {62'd0, com_valid}, {62'd0, v.e_cv});
      chk($sformatf("r%0d trap_valid", i), {63'd0, trap_valid}, {63'd0, v.e_trap});
      chk($sformatf("r%0d retire_cnt", i), retire_cnt, v.e_cnt);
      exp_wr = {v.e_cv[1] & ~v.e_pc1[4], v.e_cv[0] & ~v.e_pc0[4]};
      chk($sformatf("r%0d com_wr_en", i), {62'd0, com_wr_en}, {62'd0, exp_wr});
      for (int l = 0; l < 2; l++) begin
        if (v.e_cv[l]) begin
          lane_pc = (l == 0) ? v.e_pc0 : v.e_pc1;
          chk($sformatf("r%0d com_pc%0d", i, l), com_pc[64*l +: 64], lane_pc);
          chk($sformatf("r%0d com_data%0d", i, l), com_data[64*l +: 64], lane_pc + 64'h100);
          chk($sformatf("r%0d com_inst%0d", i, l), {32'd0, com_inst[32*l +: 32]}, {32'd0, lane_pc[31:0]});
        end
      end
      if (v.e_trap) begin
        chk($sformatf("r%0d trap_pc", i), trap_pc, v.e_tpc);
        chk($sformatf("r%0d trap_cause", i), {60'd0, trap_cause}, {60'd0, v.e_tcause});
      end
    end

    // unused lane keeps its last retired fields
    chk("hold com_pc1", com_pc[127:64], 64'h500c);

    // mid-operation reset with five entries buffered
    drive(0,1,2'b11,'h7000,'h7004,0,0); @(posedge clk); #1;
    drive(0,1,2'b11,'h7008,'h700c,0,0); @(posedge clk); #1;
    drive(0,1,2'b01,'h7010,0,0,0);      @(posedge clk); #1;
    drive(1,0,2'b00,0,0,0,0);
    #1;
    chk("rst wb_ready_during", {63'd0, wb_ready}, 64'd0);
    @(posedge clk); #1;
    chk("rst com_valid", {62'd0, com_valid}, 64'd0);
    chk("rst com_pc", com_pc[63:0] | com_pc[127:64], 64'd0);
    chk("rst com_data", com_data[63:0] | com_data[127:64], 64'd0);
    chk("rst com_inst", com_inst, 64'd0);
    chk("rst com_rd_wr", {52'd0, com_rd_addr, com_wr_en}, 64'd0);
    chk("rst trap", {59'd0, trap_valid, trap_cause}, 64'd0);
    chk("rst trap_pc", trap_pc, 64'd0);
    chk("rst retire_cnt", retire_cnt, 64'd0);
    drive(0,0,2'b00,0,0,0,0);
    #1;
    chk("rst wb_ready_after", {63'd0, wb_ready}, 64'd1);
    @(posedge clk); #1;
    chk("rst discarded", {62'd0, com_valid}, 64'd0);
    chk("rst retire_cnt_after", retire_cnt, 64'd0);

    // 20 single-lane instructions with sparse stalls; pointers wrap past DEPTH
    issued = 0; retired = 0; cyc = 0;
    while (retired < 20 && cyc < 200) begin
      st = (cyc % 5 == 2);
      pc0 = 64'h8000 + 64'(4 * issued);
      pc1 = 64'd0;
      drive(0, st, 2'b00, pc0, pc1, 0, 0);
      #1;
      can = (issued < 20) && wb_ready;
      if (can) drive(0, st, 2'b01, pc0, pc1, 0, 0);
      @(posedge clk); #1;
      if (can) issued++;
      if (st) chk($sformatf("wrap c%0d stall_cv", cyc), {62'd0, com_valid}, 64'd0);
      for (int l = 0; l < 2; l++) begin
        if (com_valid[l]) begin
          chk($sformatf("wrap order%0d", retired), com_pc[64*l +: 64], 64'h8000 + 64'(4 * retired));
          retired++;
        end
      end
      cyc++;
    end
    chk("wrap retired_all", 64'(retired), 64'd20);
    chk("wrap retire_cnt", retire_cnt, 64'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
